// File: rtl/click_if.sv
// Press-in / gesture-out bundle between the debounce stage and the click decoder.
// The decoder takes the slave side; the debounce stage (or a bench) takes the master side.
interface click_if #(
    parameter int MODE_W = 2
);
    logic              press;
    logic              click_valid;
    logic [1:0]        click_count;
    logic [MODE_W-1:0] mode;
    logic              busy;

    modport master (
        output press,
        input  click_valid,
        input  click_count,
        input  mode,
        input  busy
    );

    modport slave (
        input  press,
        output click_valid,
        output click_count,
        output mode,
        output busy
    );
endinterface

// File: rtl/click_decoder.sv
// Groups press pulses into 1/2/3-click gestures within a timeout window
// and steps a light-stick mode index on each completed gesture.
module click_decoder #(
    parameter int WINDOW_CYCLES = 25000000,
    parameter int NUM_MODES     = 4,
    parameter int MODE_W        = 2
) (
    input  logic   clk,
    input  logic   rst,
    click_if.slave bus
);
    localparam int TW = $clog2(WINDOW_CYCLES);
    localparam logic [TW-1:0]     T_LAST = TW'(WINDOW_CYCLES - 1);
    localparam logic [MODE_W-1:0] M_LAST = MODE_W'(NUM_MODES - 1);

    typedef enum logic {
        IDLE,
        COUNTING
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic              valid_q, valid_d;
    logic [1:0]        count_q, count_d;
    logic [MODE_W-1:0] mode_q, mode_d;
    logic              busy_q, busy_d;

    logic              emit;
    logic [1:0]        emit_cnt;

    // Gesture collection; a press always wins over the timeout at the same edge.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        timer_d  = timer_q;
        emit     = 1'b0;
        emit_cnt = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (bus.press) begin
                    state_d = COUNTING;
                    cnt_d   = 2'd1;
                    timer_d = '0;
                end
            end
            COUNTING: begin
                if (bus.press) begin
                    if (cnt_q == 2'd2) begin
                        emit     = 1'b1;
                        emit_cnt = 2'd3;
                        state_d  = IDLE;
                        cnt_d    = 2'd0;
                        timer_d  = '0;
                    end else begin
                        cnt_d   = cnt_q + 2'd1;
                        timer_d = '0;
                    end
                end else if (timer_q == T_LAST) begin
                    emit    = 1'b1;
                    state_d = IDLE;
                    cnt_d   = 2'd0;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
        endcase
    end

    always_comb begin
        mode_d  = mode_q;
        valid_d = emit;
        count_d = emit ? emit_cnt : count_q;
        busy_d  = (state_d == COUNTING);
        unique case (1'b1)
            emit && emit_cnt == 2'd1:
                mode_d = (mode_q == M_LAST) ? '0 : mode_q + MODE_W'(1);
            emit && emit_cnt == 2'd2:
                mode_d = (mode_q == '0) ? M_LAST : mode_q - MODE_W'(1);
            emit && emit_cnt == 2'd3:
                mode_d = '0;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            timer_q <= '0;
            valid_q <= 1'b0;
            count_q <= '0;
            mode_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            timer_q <= timer_d;
            valid_q <= valid_d;
            count_q <= count_d;
            mode_q  <= mode_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.click_valid = valid_q;
    assign bus.click_count = count_q;
    assign bus.mode        = mode_q;
    assign bus.busy        = busy_q;
endmodule

// File: tb/tb_click_decoder.sv
// Directed bench for click_decoder with an 8-cycle window and 4 modes.
// Each segment lists press edges and hand-derived emission/busy/mode expectations.
module tb_click_decoder;
    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;

    click_if #(.MODE_W(2)) bus ();

    click_decoder #(
        .WINDOW_CYCLES(8),
        .NUM_MODES    (4),
        .MODE_W       (2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] rng(input int lo, input int hi);
        logic [63:0] r;
        r = '0;
        for (int i = lo; i <= hi; i++) r[i] = 1'b1;
        return r;
    endfunction

    function automatic logic [63:0] bits(input int a, input int b,
                                         input int c, input int d);
        logic [63:0] r;
        r = '0;
        if (a > 0) r[a] = 1'b1;
        if (b > 0) r[b] = 1'b1;
        if (c > 0) r[c] = 1'b1;
        if (d > 0) r[d] = 1'b1;
        return r;
    endfunction

    // Edges are numbered 1..n from the segment start; e1/e2 = 0 means none.
    task automatic seg(input string name, input logic [63:0] pm,
                       input logic [63:0] bm, input int n, input int rst_e,
                       input logic [1:0] m0,
                       input int e1, input logic [1:0] c1, input logic [1:0] m1,
                       input int e2, input logic [1:0] c2, input logic [1:0] m2);
        logic [1:0] m_exp;
        m_exp = m0;
        for (int k = 1; k <= n; k++) begin
            bus.press = pm[k];
            rst       = (k == rst_e);
            @(posedge clk);
            #1;
            if (k == e1) m_exp = m1;
            if (k == e2) m_exp = m2;
            if (k == rst_e) m_exp = 2'd0;
            check($sformatf("%s e%0d valid", name, k),
                  32'(bus.click_valid), 32'((k == e1) || (k == e2)));
            check($sformatf("%s e%0d busy", name, k),
                  32'(bus.busy), 32'(bm[k]));
            check($sformatf("%s e%0d mode", name, k),
                  32'(bus.mode), 32'(m_exp));
            if (k == e1)
                check($sformatf("%s e%0d count", name, k),
                      32'(bus.click_count), 32'(c1));
            if (k == e2)
                check($sformatf("%s e%0d count", name, k),
                      32'(bus.click_count), 32'(c2));
        end
        bus.press = 1'b0;
        rst       = 1'b0;
    endtask

    initial begin
        n_chk     = 0;
        n_fail    = 0;
        rst       = 1'b1;
        bus.press = 1'b0;

        for (int i = 0; i < 3; i++) begin
            bus.press = (i % 2 == 0);
            @(posedge clk);
            #1;
            check($sformatf("rst c%0d valid", i), 32'(bus.click_valid), 0);
            check($sformatf("rst c%0d count", i), 32'(bus.click_count), 0);
            check($sformatf("rst c%0d mode", i), 32'(bus.mode), 0);
            check($sformatf("rst c%0d busy", i), 32'(bus.busy), 0);
        end
        bus.press = 1'b0;
        rst       = 1'b0;

        seg("single0", bits(5, 0, 0, 0), rng(5, 12), 16, 0, 2'd0,
            13, 2'd1, 2'd1, 0, 2'd0, 2'd0);
        seg("single1", bits(5, 0, 0, 0), rng(5, 12), 16, 0, 2'd1,
            13, 2'd1, 2'd2, 0, 2'd0, 2'd0);
        seg("single2", bits(5, 0, 0, 0), rng(5, 12), 16, 0, 2'd2,
            13, 2'd1, 2'd3, 0, 2'd0, 2'd0);
        seg("wrapup", bits(5, 0, 0, 0), rng(5, 12), 16, 0, 2'd3,
            13, 2'd1, 2'd0, 0, 2'd0, 2'd0);

        seg("double", bits(5, 9, 0, 0), rng(5, 16), 20, 0, 2'd0,
            17, 2'd2, 2'd3, 0, 2'd0, 2'd0);
        seg("double2", bits(5, 9, 0, 0), rng(5, 16), 20, 0, 2'd3,
            17, 2'd2, 2'd2, 0, 2'd0, 2'd0);

        seg("triple", bits(5, 7, 9, 10), rng(5, 8) | rng(10, 17), 22, 0, 2'd2,
            9, 2'd3, 2'd0, 18, 2'd1, 2'd1);

        seg("bound_in", bits(5, 13, 0, 0), rng(5, 20), 24, 0, 2'd1,
            21, 2'd2, 2'd0, 0, 2'd0, 2'd0);
        seg("bound_out", bits(5, 14, 0, 0), rng(5, 12) | rng(14, 21), 25, 0,
            2'd0, 13, 2'd1, 2'd1, 22, 2'd1, 2'd2);

        seg("rst_mid", bits(5, 7, 0, 0), rng(5, 8), 20, 9, 2'd2,
            0, 2'd0, 2'd0, 0, 2'd0, 2'd0);
        seg("after_rst", bits(5, 0, 0, 0), rng(5, 12), 16, 0, 2'd0,
            13, 2'd1, 2'd1, 0, 2'd0, 2'd0);

        seg("burst", bits(5, 6, 7, 0), rng(5, 6), 12, 0, 2'd1,
            7, 2'd3, 2'd0, 0, 2'd0, 2'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
